// File: rtl/ifns_pkg.sv
// Shared IFNS constants for the crosstalk-avoidance encoder family and the
// gearbox that feeds it, plus the helper that sizes the gearbox bit counter.
package ifns_pkg;

  localparam int IFNS_DATA_W = 14;
  localparam int IFNS_CODE_W = 20;
  localparam int IFNS_IN_W   = 32;
  localparam int IFNS_BUF_W  = 64;

  // Counter must hold every value 0..buf_w inclusive.
  function automatic int cnt_width(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/ifns_tx_gearbox.sv
// Repacks a 32-bit valid/ready word stream LSB-first into 14-bit encoder chunks.
// Define IFNS_GBX_FLUSH_EN to drain and zero-pad the residue after an in_last word.
module ifns_tx_gearbox
  import ifns_pkg::*;
#(
  parameter int IN_W  = IFNS_IN_W,
  parameter int OUT_W = IFNS_DATA_W,
  parameter int BUF_W = IFNS_BUF_W
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int CW = cnt_width(BUF_W);

  if (BUF_W < IN_W + OUT_W - 1) begin : g_bad_buf_w
    $error("ifns_tx_gearbox: BUF_W must be at least IN_W + OUT_W - 1");
  end

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_pop;
  logic [BUF_W-1:0] buf_nxt;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_pop;
  logic [CW-1:0]    cnt_nxt;
  logic             push;
  logic             pop;
  logic             flush_pend;

  // Only registered state feeds the handshakes, so out_ready never reaches in_ready.
  assign in_ready  = (cnt_q <= CW'(BUF_W - IN_W)) && !flush_pend;
  assign out_valid = (cnt_q >= CW'(OUT_W)) || (flush_pend && (cnt_q != '0));
  assign out_data  = buf_q[OUT_W-1:0];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The pop is applied first so an incoming word lands directly above the survivors.
  always_comb begin
    buf_pop = buf_q;
    cnt_pop = cnt_q;
    if (pop) begin
      buf_pop = buf_q >> OUT_W;
      cnt_pop = (cnt_q >= CW'(OUT_W)) ? cnt_q - CW'(OUT_W) : '0;
    end
    buf_nxt = buf_pop;
    cnt_nxt = cnt_pop;
    if (push) begin
      buf_nxt = buf_pop | (BUF_W'(in_data) << cnt_pop);
      cnt_nxt = cnt_pop + CW'(IN_W);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_nxt;
      cnt_q <= cnt_nxt;
    end
  end

`ifdef IFNS_GBX_FLUSH_EN
  // Pending flush blocks input until the pop that empties the buffer.
  always_ff @(posedge clock) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (push && in_last) begin
      flush_pend <= 1'b1;
    end else if (pop && (cnt_pop == '0)) begin
      flush_pend <= 1'b0;
    end
  end

  assign out_last = flush_pend && out_valid && (cnt_q <= CW'(OUT_W));
`else
  logic unused_in_last;

  assign unused_in_last = in_last;
  assign flush_pend     = 1'b0;
  assign out_last       = 1'b0;
`endif

  cnt_bound_a : assert property (@(posedge clock) disable iff (rst) cnt_q <= CW'(BUF_W));

endmodule

// File: tb/tb_ifns_tx_gearbox.sv
// Self-checking bench for ifns_tx_gearbox: a bit-queue model of the gearbox
// checked every cycle, plus hand-computed chunk values for directed streams.
module tb_ifns_tx_gearbox;

  localparam int IN_W  = 32;
  localparam int OUT_W = 14;
  localparam int BUF_W = 64;

  logic              clock = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  int n_cmp  = 0;
  int n_fail = 0;

  bit               mq[$];
  bit               m_flush = 1'b0;
  bit               check_en = 1'b0;
  logic [OUT_W-1:0] got[$];
  bit               got_last[$];

  ifns_tx_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W), .BUF_W(BUF_W)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: the buffer is just an ordered queue of not-yet-emitted bits.
  function automatic bit exp_in_ready();
    return (mq.size() <= BUF_W - IN_W) && !m_flush;
  endfunction

  function automatic bit exp_out_valid();
    return (mq.size() >= OUT_W) || (m_flush && mq.size() > 0);
  endfunction

  function automatic bit exp_out_last();
    return m_flush && (mq.size() > 0) && (mq.size() <= OUT_W);
  endfunction

  function automatic logic [OUT_W-1:0] exp_data();
    logic [OUT_W-1:0] d;
    d = '0;
    for (int i = 0; i < OUT_W; i++)
      if (i < mq.size()) d[i] = mq[i];
    return d;
  endfunction

  always @(posedge clock) begin
    bit pu;
    bit po;
    int n;
    if (rst) begin
      mq.delete();
      m_flush = 1'b0;
    end else begin
      pu = in_valid && exp_in_ready();
      po = exp_out_valid() && out_ready;
      if (po) begin
        n = (mq.size() < OUT_W) ? mq.size() : OUT_W;
        repeat (n) void'(mq.pop_front());
        if (mq.size() == 0) m_flush = 1'b0;
      end
      if (pu) begin
        for (int i = 0; i < IN_W; i++) mq.push_back(in_data[i]);
`ifdef IFNS_GBX_FLUSH_EN
        if (in_last) m_flush = 1'b1;
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("in_ready", 32'(in_ready), 32'(exp_in_ready()));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_out_valid()));
      checkOutput("out_last", 32'(out_last), 32'(exp_out_last()));
      if (exp_out_valid()) checkOutput("out_data", 32'(out_data), 32'(exp_data()));
      if (out_valid && out_ready && !rst) begin
        got.push_back(out_data);
        got_last.push_back(out_last);
      end
    end
  end

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit l);
    int  budget;
    bit  acc;
    budget   = 50;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    do begin
      acc = in_ready;
      applyStimulus();
      budget--;
    end while (!acc && budget > 0);
    checkOutput("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_chunks(input int n);
    int budget;
    budget = 80;
    while (got.size() < n && budget > 0) begin
      applyStimulus();
      budget--;
    end
    repeat (4) applyStimulus();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    got.delete();
    got_last.delete();
  endtask

  initial begin
    logic [223:0] all_bits;
    logic [3:0]   nib;
    int           acc;
    int           lasts;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    check_en = 1'b1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Seven nibble-pattern words, 224 bits, exactly sixteen chunks.
    out_ready = 1'b1;
    for (int w = 0; w < 7; w++) begin
      nib = 4'(w);
      all_bits[32*w +: 32] = {8{nib}};
      send_word({8{nib}}, 1'b0);
    end
    wait_chunks(16);
    checkOutput("stream_count", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      checkOutput("stream_chunk2", 32'(got[2]), 32'h1110);
      for (int k = 0; k < 16; k++)
        checkOutput("stream_chunk", 32'(got[k]), 32'(all_bits[14*k +: 14]));
    end

    // Continuous traffic: input acceptance settles at about 14/32 of cycles.
    do_reset();
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 256; c++) begin
      in_data = $urandom;
      if (in_ready) acc++;
      applyStimulus();
    end
    in_valid = 1'b0;
    checkOutput("duty_low", 32'(acc * 32 >= 256 * 14 - 64), 32'd1);
    checkOutput("duty_high", 32'(acc * 32 <= 256 * 14 + 64), 32'd1);

    // Mid-stream reset drops the residue; the next word starts clean.
    out_ready = 1'b0;
    do_reset();
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_out_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    send_word(32'h0000_3FFF, 1'b0);
    wait_chunks(2);
    checkOutput("post_rst_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      checkOutput("post_rst_chunk0", 32'(got[0]), 32'h3FFF);
      checkOutput("post_rst_chunk1", 32'(got[1]), 32'h0000);
    end

    // Downstream stall: buffer fills to 64 bits and holds its head chunk.
    out_ready = 1'b0;
    do_reset();
    send_word(32'hA5A5_1234, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    repeat (3) applyStimulus();
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_data", 32'(out_data), 32'h1234);
    repeat (3) applyStimulus();
    checkOutput("stall_data_hold", 32'(out_data), 32'h1234);
    out_ready = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("stall_release_count", 32'(got.size()), 32'd4);
    checkOutput("stall_release_in_ready", 32'(in_ready), 32'd1);
    if (got.size() == 4) checkOutput("stall_chunk1", 32'(got[1]), 32'h1694);

`ifdef IFNS_GBX_FLUSH_EN
    // Single all-ones last word drains as two full chunks and one padded chunk.
    do_reset();
    send_word(32'hFFFF_FFFF, 1'b1);
    wait_chunks(3);
    checkOutput("flush1_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      checkOutput("flush1_chunk0", 32'(got[0]), 32'h3FFF);
      checkOutput("flush1_chunk1", 32'(got[1]), 32'h3FFF);
      checkOutput("flush1_chunk2", 32'(got[2]), 32'h000F);
      checkOutput("flush1_last0", 32'(got_last[0]), 32'd0);
      checkOutput("flush1_last1", 32'(got_last[1]), 32'd0);
      checkOutput("flush1_last2", 32'(got_last[2]), 32'd1);
    end
    checkOutput("flush1_in_ready", 32'(in_ready), 32'd1);

    // 224-bit burst is an exact multiple of 14: no padding chunk is added.
    do_reset();
    for (int w = 0; w < 7; w++) send_word(32'h1357_9BDF ^ 32'(w), w == 6);
    wait_chunks(16);
    checkOutput("flush7_count", 32'(got.size()), 32'd16);
    lasts = 0;
    foreach (got_last[k]) lasts += int'(got_last[k]);
    checkOutput("flush7_last_total", 32'(lasts), 32'd1);
    if (got.size() == 16) checkOutput("flush7_last_pos", 32'(got_last[15]), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
